bits_stream_demux: RTL and testbench



---
 rtl/bits_stream_pkg.sv | 15 +
 rtl/bits_stream_demux_stream_slot.sv | 45 ++++
 rtl/bits_stream_demux.sv | 75 +++++++
 tb/tb_bits_stream_demux.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bits_stream_pkg.sv
// Shared routing definitions for the bits-select mux/demux pair.
package bits_stream_pkg;

   // Widest select the shared predicate accepts; callers zero-extend into it.
   localparam int SEL_MAX_W = 64;

   localparam logic SEL_O0 = 1'b0;
   localparam logic SEL_O1 = 1'b1;

   // Any non-zero select routes to output 1; identical to the mux predicate.
   function automatic logic route_sel(input logic [SEL_MAX_W-1:0] s);
      return (s != '0);
   endfunction

endpackage

// File: rtl/bits_stream_demux_stream_slot.sv
// One-entry registered output slot with valid/ready and a saturating
// delivery counter.
module stream_slot #(
   parameter int WIDTH       = 3,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   load,
   input  logic [WIDTH-1:0]       din,
   input  logic                   ready,
   output logic                   can_load,
   output logic                   valid,
   output logic [WIDTH-1:0]       data,
   output logic [COUNT_WIDTH-1:0] cnt
);

   logic fire;

   // Slot accepts when empty or when its current word leaves this edge.
   assign can_load = ~valid | ready;
   assign fire     = valid & ready;

   // Data/valid register; a load on a draining edge keeps valid high.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
      end else if (fire) begin
         valid <= 1'b0;
      end
   end

   // Delivered-word counter, sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!resetn)
         cnt <= '0;
      else if (fire && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/bits_stream_demux.sv
// Streaming 1:2 demux: each accepted word goes to slot 0 when S == 0,
// otherwise to slot 1. Only I_ready is combinational.
module bits_stream_demux
   import bits_stream_pkg::*;
#(
   parameter int WIDTH       = 3,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   CLK,
   input  logic                   RESETN,
   input  logic [WIDTH-1:0]       I,
   input  logic [WIDTH-1:0]       S,
   input  logic                   I_valid,
   output logic                   I_ready,
   output logic [WIDTH-1:0]       O0,
   output logic                   O0_valid,
   input  logic                   O0_ready,
   output logic [WIDTH-1:0]       O1,
   output logic                   O1_valid,
   input  logic                   O1_ready,
   output logic [COUNT_WIDTH-1:0] CNT0,
   output logic [COUNT_WIDTH-1:0] CNT1
);

   logic [SEL_MAX_W-1:0]          s_ext;
   logic                          sel;
   logic                          accept;
   logic [1:0]                    can_load;
   logic [1:0]                    load;
   logic [1:0]                    ready;
   logic [1:0]                    valid;
   logic [1:0][WIDTH-1:0]         data;
   logic [1:0][COUNT_WIDTH-1:0]   cnt;

   // Select decode through the shared predicate.
   always_comb begin
      s_ext            = '0;
      s_ext[WIDTH-1:0] = S;
      sel              = route_sel(s_ext);
   end

   // Ready depends only on the addressed slot, never on I_valid.
   assign I_ready = RESETN & can_load[sel];
   assign accept  = I_valid & I_ready;

   assign load[SEL_O0]  = accept & (sel == SEL_O0);
   assign load[SEL_O1]  = accept & (sel == SEL_O1);
   assign ready[SEL_O0] = O0_ready;
   assign ready[SEL_O1] = O1_ready;

   for (genvar k = 0; k < 2; k++) begin : g_slot
      stream_slot #(
         .WIDTH      (WIDTH),
         .COUNT_WIDTH(COUNT_WIDTH)
      ) u_slot (
         .clk     (CLK),
         .resetn  (RESETN),
         .load    (load[k]),
         .din     (I),
         .ready   (ready[k]),
         .can_load(can_load[k]),
         .valid   (valid[k]),
         .data    (data[k]),
         .cnt     (cnt[k])
      );
   end

   assign O0       = data[SEL_O0];
   assign O0_valid = valid[SEL_O0];
   assign CNT0     = cnt[SEL_O0];
   assign O1       = data[SEL_O1];
   assign O1_valid = valid[SEL_O1];
   assign CNT1     = cnt[SEL_O1];

endmodule

// File: tb/tb_bits_stream_demux.sv
// Directed bench for bits_stream_demux: a word-level model checked every
// cycle, plus literal expectations from hand-worked scenarios. A second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_bits_stream_demux;

   localparam int W = 3;

   logic         CLK = 1'b0;
   logic         RESETN;
   logic [W-1:0] I, S;
   logic         I_valid, O0_ready, O1_ready;

   logic         I_ready, O0_valid, O1_valid;
   logic [W-1:0] O0, O1;
   logic [7:0]   CNT0, CNT1;

   logic         s_I_ready, s_O0_valid, s_O1_valid;
   logic [W-1:0] s_O0, s_O1;
   logic [1:0]   s_CNT0, s_CNT1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   bits_stream_demux #(.WIDTH(W), .COUNT_WIDTH(8)) dut (
      .CLK(CLK), .RESETN(RESETN), .I(I), .S(S), .I_valid(I_valid), .I_ready(I_ready),
      .O0(O0), .O0_valid(O0_valid), .O0_ready(O0_ready),
      .O1(O1), .O1_valid(O1_valid), .O1_ready(O1_ready),
      .CNT0(CNT0), .CNT1(CNT1));

   bits_stream_demux #(.WIDTH(W), .COUNT_WIDTH(2)) dut_sat (
      .CLK(CLK), .RESETN(RESETN), .I(I), .S(S), .I_valid(I_valid), .I_ready(s_I_ready),
      .O0(s_O0), .O0_valid(s_O0_valid), .O0_ready(O0_ready),
      .O1(s_O1), .O1_valid(s_O1_valid), .O1_ready(O1_ready),
      .CNT0(s_CNT0), .CNT1(s_CNT1));

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- word-level model ----------------
   // Each destination is a single-word mailbox; counters are unbounded here
   // and clipped to the counter width when compared.
   bit model_ok = 0;
   bit mv[2];
   int md[2];
   int mc[2];

   function automatic int dest(input logic [W-1:0] s);
      return (s == 0) ? 0 : 1;
   endfunction

   function automatic bit exp_ready();
      bit r[2];
      r[0] = O0_ready;
      r[1] = O1_ready;
      return RESETN && (!mv[dest(S)] || r[dest(S)]);
   endfunction

   always @(posedge CLK) begin
      bit r[2];
      bit take;
      int d;
      r[0] = O0_ready;
      r[1] = O1_ready;
      if (!RESETN) begin
         model_ok = 1;
         for (int k = 0; k < 2; k++) begin
            mv[k] = 0; md[k] = 0; mc[k] = 0;
         end
      end else if (model_ok) begin
         take = I_valid && exp_ready();
         d    = dest(S);
         for (int k = 0; k < 2; k++) begin
            if (mv[k] && r[k]) begin
               mc[k]++;
               mv[k] = 0;
            end
         end
         if (take) begin
            mv[d] = 1;
            md[d] = int'(I);
         end
      end
   end

   function automatic int clip(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Compare both instances against the model on every falling edge.
   always @(negedge CLK) begin
      if (model_ok) begin
         chk("I_ready",    int'(I_ready),    int'(exp_ready()));
         chk("s.I_ready",  int'(s_I_ready),  int'(exp_ready()));
         chk("O0_valid",   int'(O0_valid),   int'(mv[0]));
         chk("O1_valid",   int'(O1_valid),   int'(mv[1]));
         chk("s.O0_valid", int'(s_O0_valid), int'(mv[0]));
         chk("s.O1_valid", int'(s_O1_valid), int'(mv[1]));
         if (mv[0]) begin
            chk("O0",   int'(O0),   md[0]);
            chk("s.O0", int'(s_O0), md[0]);
         end
         if (mv[1]) begin
            chk("O1",   int'(O1),   md[1]);
            chk("s.O1", int'(s_O1), md[1]);
         end
         chk("CNT0",   int'(CNT0),   clip(mc[0], 255));
         chk("CNT1",   int'(CNT1),   clip(mc[1], 255));
         chk("s.CNT0", int'(s_CNT0), clip(mc[0], 3));
         chk("s.CNT1", int'(s_CNT1), clip(mc[1], 3));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic put(input int i, input int s, input bit v);
      I       = W'(i);
      S       = W'(s);
      I_valid = v;
      #1;
   endtask

   initial begin
      int seq[5];
      seq = '{1, 2, 3, 3, 3};

      // 1: reset held with a word offered
      RESETN = 0; O0_ready = 1; O1_ready = 1;
      put(5, 0, 1);
      for (int c = 0; c < 3; c++) begin
         cyc();
         chk("rst I_ready", int'(I_ready), 0);
         chk("rst O0_valid", int'(O0_valid), 0);
         chk("rst O1_valid", int'(O1_valid), 0);
         chk("rst CNT0", int'(CNT0), 0);
         chk("rst CNT1", int'(CNT1), 0);
         chk("rst O0", int'(O0), 0);
      end
      I_valid = 0;
      RESETN  = 1;
      cyc();

      // 2: 5->O0, 6 and 7 -> O1 back to back
      put(5, 0, 1); cyc();
      chk("t2 O0_valid", int'(O0_valid), 1);
      chk("t2 O0", int'(O0), 5);
      put(6, 3, 1); cyc();
      chk("t2 O1 first", int'(O1), 6);
      chk("t2 O0 drained", int'(O0_valid), 0);
      put(7, 4, 1); cyc();
      chk("t2 O1 second", int'(O1), 7);
      chk("t2 O1_valid", int'(O1_valid), 1);
      put(0, 0, 0); cyc();
      chk("t2 CNT0", int'(CNT0), 1);
      chk("t2 CNT1", int'(CNT1), 2);

      // 3: O1 stalls; the next word for O1 (and the O0 word behind it) waits
      O1_ready = 0;
      put(2, 1, 1); cyc();
      chk("t3 O1 held", int'(O1), 2);
      put(3, 1, 1);
      chk("t3 blocked", int'(I_ready), 0);
      cyc(); cyc();
      chk("t3 still blocked", int'(I_ready), 0);
      chk("t3 O1 stable", int'(O1), 2);
      O1_ready = 1; #1;
      chk("t3 unblocked", int'(I_ready), 1);
      cyc();
      chk("t3 O1 reloaded", int'(O1), 3);
      chk("t3 O1_valid", int'(O1_valid), 1);
      chk("t3 CNT1", int'(CNT1), 3);
      put(4, 0, 1); cyc();
      chk("t3 O0 late word", int'(O0), 4);

      // 4: O0 full and draining while a new O0 word arrives
      put(1, 0, 1);
      chk("t4 I_ready", int'(I_ready), 1);
      cyc();
      chk("t4 no bubble", int'(O0_valid), 1);
      chk("t4 O0", int'(O0), 1);
      chk("t4 CNT0", int'(CNT0), 2);
      put(0, 0, 0); cyc();
      chk("t4 CNT0 final", int'(CNT0), 3);
      chk("t4 O0 empty", int'(O0_valid), 0);

      // 5: fresh counters, five words to O1; 2-bit counter saturates
      RESETN = 0; cyc(); RESETN = 1;
      for (int k = 0; k < 6; k++) begin
         if (k < 5) put(k + 1, 2, 1);
         else       put(0, 0, 0);
         cyc();
         if (k >= 1) begin
            chk("t5 sat CNT1", int'(s_CNT1), seq[k-1]);
            chk("t5 CNT1", int'(CNT1), k);
         end
      end

      // 6: reset while O0 holds an undelivered word
      O0_ready = 0;
      put(6, 0, 1); cyc();
      put(0, 0, 0); cyc();
      chk("t6 O0 held", int'(O0_valid), 1);
      chk("t6 O0 data", int'(O0), 6);
      RESETN = 0; cyc();
      chk("t6 O0_valid", int'(O0_valid), 0);
      chk("t6 O0", int'(O0), 0);
      chk("t6 CNT0", int'(CNT0), 0);
      RESETN = 1; O0_ready = 1;
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
